mem_bank_atop_adapter: RTL

- Per-bank adapter between one bank port of the AXI-to-memory converter and a single-port SRAM macro with fixed 1-cycle read latency.
- Converts the req/gnt/rvalid bank protocol into SRAM req/we/be strobes.
- Guarantees exactly one rvalid per granted request, for reads and for writes.
- Executes AXI5 atomic operations (ATOPs) as an atomic read-modify-write on the SRAM and returns the old value.
- One instance per bank, placed directly downstream of each mem_* bank lane.

---
 rtl/mem_bank_atop_adapter_pkg.sv | 31 +++
 rtl/mem_bank_atop_adapter_alu.sv | 40 ++++
 rtl/mem_bank_atop_adapter.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_bank_atop_adapter_pkg.sv
// Shared encodings for the bank ATOP adapter:
// atop classes, AMO op codes and adapter FSM states.
package mem_bank_atop_adapter_pkg;

  typedef logic [5:0] atop_t;

  localparam logic [1:0] ATOP_NONE     = 2'b00;
  localparam logic [1:0] ATOP_STORE    = 2'b01;
  localparam logic [1:0] ATOP_LOAD     = 2'b10;
  localparam logic [1:0] ATOP_SWAP_CMP = 2'b11;

  localparam atop_t ATOP_SWAP = 6'b110000;
  localparam atop_t ATOP_CMP  = 6'b110001;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_CLR  = 3'd1,
    OP_EOR  = 3'd2,
    OP_SET  = 3'd3,
    OP_SMAX = 3'd4,
    OP_SMIN = 3'd5,
    OP_UMAX = 3'd6,
    OP_UMIN = 3'd7
  } amo_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    AMO  = 1'b1
  } adp_state_e;

endpackage

// File: rtl/mem_bank_atop_adapter_alu.sv
// Combinational AMO datapath: computes the new
// memory word from the old word and the operand.
module mem_atop_alu
  import mem_bank_atop_adapter_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  amo_op_e              i_op,
  input  logic                 i_swap,
  input  logic [DataWidth-1:0] i_old,
  input  logic [DataWidth-1:0] i_operand,
  output logic [DataWidth-1:0] o_new
);

  logic w_slt;
  logic w_ult;

  assign w_slt = $signed(i_old) < $signed(i_operand);
  assign w_ult = i_old < i_operand;

  always_comb begin
    o_new = i_old;
    if (i_swap) begin
      o_new = i_operand;
    end else begin
      case (i_op)
        OP_ADD:  o_new = i_old + i_operand;
        OP_CLR:  o_new = i_old & ~i_operand;
        OP_EOR:  o_new = i_old ^ i_operand;
        OP_SET:  o_new = i_old | i_operand;
        OP_SMAX: o_new = w_slt ? i_operand : i_old;
        OP_SMIN: o_new = w_slt ? i_old : i_operand;
        OP_UMAX: o_new = w_ult ? i_operand : i_old;
        OP_UMIN: o_new = w_ult ? i_old : i_operand;
        default: o_new = i_old;
      endcase
    end
  end

endmodule

// File: rtl/mem_bank_atop_adapter.sv
// Bank-port to 1-cycle SRAM adapter with in-place
// atomic read-modify-write support.
module mem_bank_atop_adapter
  import mem_bank_atop_adapter_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter bit          AtopSupport = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   busy_o,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  input  atop_t                  mem_atop_i,
  input  logic                   mem_we_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   sram_req_o,
  output logic                   sram_we_o,
  output logic [AddrWidth-1:0]   sram_addr_o,
  output logic [DataWidth-1:0]   sram_wdata_o,
  output logic [DataWidth/8-1:0] sram_be_o,
  input  logic [DataWidth-1:0]   sram_rdata_i
);

  localparam int unsigned BeW = DataWidth / 8;

  adp_state_e           r_state;
  logic                 r_rvalid;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata;
  logic [BeW-1:0]       r_strb;
  atop_t                r_atop;

  logic                 w_is_amo;
  logic                 w_cmp;
  logic                 w_swap;
  logic [DataWidth-1:0] w_new;

  assign w_is_amo = AtopSupport &&
                    (mem_atop_i[5:4] != ATOP_NONE);
  assign w_cmp    = (r_atop == ATOP_CMP);
  assign w_swap   = (r_atop[5:4] == ATOP_SWAP_CMP);

  mem_atop_alu #(
    .DataWidth (DataWidth)
  ) u_alu (
    .i_op      (amo_op_e'(r_atop[2:0])),
    .i_swap    (w_swap),
    .i_old     (sram_rdata_i),
    .i_operand (r_wdata),
    .o_new     (w_new)
  );

  // The SRAM port is owned by the bank in IDLE and
  // by the write-back half of the atomic in AMO.
  always_comb begin
    mem_gnt_o    = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = mem_addr_i;
    sram_wdata_o = mem_wdata_i;
    sram_be_o    = mem_strb_i;
    if (r_state == IDLE) begin
      mem_gnt_o  = mem_req_i;
      sram_req_o = mem_req_i;
      sram_we_o  = mem_we_i & ~w_is_amo;
      if (w_is_amo) sram_be_o = '1;
    end else begin
      sram_req_o   = ~w_cmp;
      sram_we_o    = 1'b1;
      sram_addr_o  = r_addr;
      sram_wdata_o = w_new;
      sram_be_o    = r_strb;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_rvalid <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_atop   <= '0;
    end else begin
      r_rvalid <= (r_state == IDLE) & mem_req_i;
      case (r_state)
        IDLE: begin
          if (mem_req_i && w_is_amo) begin
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_strb  <= mem_strb_i;
            r_atop  <= mem_atop_i;
            r_state <= AMO;
          end
        end
        AMO:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rvalid_o = r_rvalid;
  assign mem_rdata_o  = sram_rdata_i;
  assign busy_o       = (r_state == AMO) | r_rvalid;

endmodule
